hazard3_sd_dma: RTL and testbench

Sector DMA engine that moves data between the SD block buffer (128 x 32-bit words, one 512-byte sector) and system RAM over an AHB5 master port. It sits directly downstream of the SD APB bridge's block buffer: software programs it over APB after a sector read completes (buffer -> RAM) or before a sector write (RAM -> buffer). This removes the 128 programmed-I/O APB accesses per sector from the CPU.

---
 rtl/hazard3_sd_dma_if.sv | 54 +++++
 rtl/hazard3_sd_dma.sv | 167 ++++++++++++++++
 tb/tb_hazard3_sd_dma.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard3_sd_dma_if.sv
// Bus bundle for the SD sector DMA: APB register port, AHB5 master port and block-buffer port.
// APB writes commit on psel&penable&pwrite (pready tied high). An AHB address phase is taken on a
// cycle with htrans=NONSEQ and hready=1; its data phase ends on the next hready=1, or aborts on
// hresp=1. buf_we writes buf_wdata at buf_addr on the edge that ends the cycle in which it is high.
interface hazard3_sd_dma_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [15:0]       paddr;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic              pslverr;

  logic [W_ADDR-1:0] haddr;
  logic              hwrite;
  logic [1:0]        htrans;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic              hexcl;
  logic              hready;
  logic              hresp;
  logic [W_DATA-1:0] hwdata;
  logic [W_DATA-1:0] hrdata;

  logic [6:0]        buf_addr;
  logic [31:0]       buf_rdata;
  logic [31:0]       buf_wdata;
  logic              buf_we;

  // master is the DMA engine side; slave is the surrounding system (APB bridge, AHB fabric, buffer)
  modport master (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr,
    output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    input  hready, hresp, hrdata,
    output buf_addr, buf_wdata, buf_we,
    input  buf_rdata
  );

  modport slave (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr,
    input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hexcl, hwdata,
    output hready, hresp, hrdata,
    input  buf_addr, buf_wdata, buf_we,
    output buf_rdata
  );
endinterface

// File: rtl/hazard3_sd_dma.sv
// Sector DMA between the SD block buffer and system RAM: APB-programmed, single-beat AHB5 master,
// one word per ADDR/DATA pair, abort on AHB error.
module hazard3_sd_dma #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int BUF_WORDS = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard3_sd_dma_if.master bus,
  output logic             irq,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [8:0] MAX_LEN       = 9'(BUF_WORDS);

  state_t            state;
  logic              dir_q;
  logic              irq_en_q;
  logic              done_q;
  logic              err_q;
  logic [W_ADDR-1:2] ram_addr_q;
  logic [7:0]        len_q;
  logic [7:0]        idx_q;

  logic              busy;
  logic              apb_wr;
  logic [1:0]        reg_sel;
  logic              start_req;
  logic              len_bad;
  logic              last;
  logic [7:0]        idx_inc;
  logic              unused_paddr;

  assign busy      = (state != S_IDLE);
  assign apb_wr    = bus.psel & bus.penable & bus.pwrite;
  assign reg_sel   = bus.paddr[3:2];
  assign start_req = apb_wr && (reg_sel == 2'd0) && bus.pwdata[0] && !busy;
  assign len_bad   = (len_q == 8'd0) || ({1'b0, len_q} > MAX_LEN);
  assign idx_inc   = idx_q + 8'd1;
  assign last      = (idx_q == len_q - 8'd1);
  assign unused_paddr = ^{bus.paddr[15:4], bus.paddr[1:0]};

  assign bus.pready    = 1'b1;
  assign bus.pslverr   = 1'b0;
  assign bus.hsize     = 3'b010;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = 4'b0011;
  assign bus.hmastlock = 1'b0;
  assign bus.hexcl     = 1'b0;

  assign irq       = irq_en_q & (done_q | err_q);
  assign dbg_state = state;

  always_comb begin
    bus.prdata = 32'd0;
    case (reg_sel)
      2'd0: bus.prdata = {29'd0, irq_en_q, dir_q, 1'b0};
      2'd1: bus.prdata = {29'd0, err_q, done_q, busy};
      2'd2: bus.prdata = 32'({ram_addr_q, 2'b00});
      2'd3: bus.prdata = {24'd0, len_q};
      default: bus.prdata = 32'd0;
    endcase
  end

  // Register writes come first so the transfer engine's DONE/ERR sets below win over a same-edge W1C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      dir_q         <= 1'b0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      ram_addr_q    <= '0;
      len_q         <= 8'd0;
      idx_q         <= 8'd0;
      bus.haddr     <= '0;
      bus.hwrite    <= 1'b0;
      bus.htrans    <= HTRANS_IDLE;
      bus.hwdata    <= '0;
      bus.buf_addr  <= 7'd0;
      bus.buf_wdata <= 32'd0;
      bus.buf_we    <= 1'b0;
    end else begin
      bus.buf_we <= 1'b0;

      if (apb_wr) begin
        case (reg_sel)
          2'd0: begin
            irq_en_q <= bus.pwdata[2];
            if (!busy) dir_q <= bus.pwdata[1];
          end
          2'd1: begin
            if (bus.pwdata[1]) done_q <= 1'b0;
            if (bus.pwdata[2]) err_q  <= 1'b0;
          end
          2'd2: if (!busy) ram_addr_q <= bus.pwdata[W_ADDR-1:2];
          2'd3: if (!busy) len_q <= bus.pwdata[7:0];
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (start_req) begin
            if (len_bad) begin
              err_q <= 1'b1;
            end else begin
              done_q       <= 1'b0;
              err_q        <= 1'b0;
              idx_q        <= 8'd0;
              bus.haddr    <= {ram_addr_q, 2'b00};
              bus.hwrite   <= !bus.pwdata[1];
              bus.htrans   <= HTRANS_NONSEQ;
              bus.buf_addr <= 7'd0;
              state        <= S_ADDR;
            end
          end
        end

        S_ADDR: begin
          if (bus.hready) begin
            if (!dir_q) bus.hwdata <= bus.buf_rdata;
            bus.htrans <= HTRANS_IDLE;
            state      <= S_DATA;
          end
        end

        S_DATA: begin
          if (bus.hresp) begin
            err_q <= 1'b1;
            state <= S_IDLE;
          end else if (bus.hready) begin
            // RAM->buffer keeps buf_addr on the word being written; buffer->RAM moves on to the next read
            if (dir_q) begin
              bus.buf_wdata <= bus.hrdata;
              bus.buf_we    <= 1'b1;
              bus.buf_addr  <= idx_q[6:0];
            end else begin
              bus.buf_addr  <= idx_inc[6:0];
            end
            idx_q     <= idx_inc;
            bus.haddr <= bus.haddr + W_ADDR'(4);
            if (last) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              bus.htrans <= HTRANS_NONSEQ;
              state      <= S_ADDR;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard3_sd_dma.sv
// Directed bench for hazard3_sd_dma: register vector table plus hand-written transfer sequences
// against a behavioural AHB slave / RAM and block-buffer model.
module tb_hazard3_sd_dma;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_STATUS = 2'd1;
  localparam logic [1:0] R_RAM    = 2'd2;
  localparam logic [1:0] R_LEN    = 2'd3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq;
  logic [1:0] dbg_state;

  hazard3_sd_dma_if bus ();

  hazard3_sd_dma dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // slave / memory model state
  int          ws = 0;
  int          err_word = -1;
  bit          data_active = 1'b0;
  bit          err_phase = 1'b0;
  int          wait_left = 0;
  int          xfer_idx = 0;
  int          nonseq_cnt = 0;
  logic [31:0] cur_addr;
  bit          cur_write;
  logic [31:0] ram [logic [31:0]];
  logic [31:0] buf_mem [128];
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] bw_idx_q[$];
  logic [31:0] bw_data_q[$];
  logic [63:0] exp_q[$];

  assign bus.buf_rdata = buf_mem[bus.buf_addr];

  // AHB slave: decides hready/hresp/hrdata for the coming edge from what the DUT presents now
  always @(negedge clk) begin
    if (!rst_n) begin
      data_active = 1'b0;
      bus.hready  = 1'b1;
      bus.hresp   = 1'b0;
      bus.hrdata  = 32'd0;
    end else if (!data_active) begin
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      if (bus.htrans == 2'b10) begin
        data_active = 1'b1;
        cur_addr    = bus.haddr;
        cur_write   = bus.hwrite;
        wait_left   = ws;
        err_phase   = 1'b0;
        xfer_idx    = nonseq_cnt;
        nonseq_cnt++;
      end
    end else if (wait_left > 0) begin
      bus.hready = 1'b0;
      bus.hresp  = 1'b0;
      wait_left--;
    end else if (xfer_idx == err_word) begin
      if (!err_phase) begin
        bus.hready = 1'b0;
        bus.hresp  = 1'b1;
        err_phase  = 1'b1;
      end else begin
        bus.hready  = 1'b1;
        bus.hresp   = 1'b1;
        data_active = 1'b0;
      end
    end else begin
      bus.hready = 1'b1;
      bus.hresp  = 1'b0;
      if (cur_write) begin
        ram[cur_addr] = bus.hwdata;
        wr_addr_q.push_back(cur_addr);
        wr_data_q.push_back(bus.hwdata);
      end else begin
        bus.hrdata = ram.exists(cur_addr) ? ram[cur_addr] : 32'hDEAD_BEEF;
      end
      data_active = 1'b0;
    end
    if (rst_n && bus.buf_we) begin
      buf_mem[bus.buf_addr] = bus.buf_wdata;
      bw_idx_q.push_back({25'd0, bus.buf_addr});
      bw_data_q.push_back(bus.buf_wdata);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [1:0] r, input logic [31:0] d);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b1;
    bus.penable = 1'b0;
    bus.paddr   = {12'd0, r, 2'b00};
    bus.pwdata  = d;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] r, output logic [31:0] d);
    bus.psel    = 1'b1;
    bus.pwrite  = 1'b0;
    bus.penable = 1'b0;
    bus.paddr   = {12'd0, r, 2'b00};
    @(negedge clk);
    bus.penable = 1'b1;
    #1 d = bus.prdata;
    @(negedge clk);
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
  endtask

  // Counts negedges until STATUS & mask is non-zero; an expired budget is a failed check.
  task automatic wait_status(input string name, input logic [31:0] mask, input int limit,
                             output int cycles);
    bus.paddr = {12'd0, R_STATUS, 2'b00};
    #1;
    cycles = 0;
    while (((bus.prdata & mask) == 32'd0) && (cycles < limit)) begin
      @(negedge clk);
      #1;
      cycles++;
    end
    check({name, "_timeout"}, cycles >= limit, 0);
  endtask

  task automatic check_writes(input string name, input int base);
    int n;
    n = exp_q.size();
    check({name, "_count"}, wr_addr_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] e;
      logic [63:0] a;
      e = exp_q.pop_front();
      a = (base + i < wr_addr_q.size()) ? {wr_addr_q[base + i], wr_data_q[base + i]} : 64'hFFFF_FFFF_FFFF_FFFF;
      check($sformatf("%s_w%0d", name, i), a, e);
    end
  endtask

  task automatic check_bufwrites(input string name, input int base);
    int n;
    n = exp_q.size();
    check({name, "_count"}, bw_idx_q.size() - base, n);
    for (int i = 0; i < n; i++) begin
      logic [63:0] e;
      logic [63:0] a;
      e = exp_q.pop_front();
      a = (base + i < bw_idx_q.size()) ? {bw_idx_q[base + i], bw_data_q[base + i]} : 64'hFFFF_FFFF_FFFF_FFFF;
      check($sformatf("%s_b%0d", name, i), a, e);
    end
  endtask

  task automatic preload_buf(input logic [31:0] base);
    for (int i = 0; i < 128; i++) buf_mem[i] = base + 32'(i);
  endtask

  typedef struct {
    bit          we;
    logic [1:0]  wreg;
    logic [31:0] wdata;
    logic [1:0]  rreg;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } reg_vec_t;

  localparam int NV = 15;
  reg_vec_t vec [NV];

  initial begin
    logic [31:0] rd;
    int cyc;
    int nb;
    int wb;
    int bb;
    int n;

    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 16'd0; bus.pwdata = 32'd0;
    preload_buf(32'd0);

    // ---- reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_htrans", bus.htrans, 2'b00);
    check("rst_haddr", bus.haddr, 32'd0);
    check("rst_hwrite", bus.hwrite, 1'b0);
    check("rst_hwdata", bus.hwdata, 32'd0);
    check("rst_buf_addr", bus.buf_addr, 7'd0);
    check("rst_buf_wdata", bus.buf_wdata, 32'd0);
    check("rst_buf_we", bus.buf_we, 1'b0);
    check("rst_irq", irq, 1'b0);
    check("rst_prdata", bus.prdata, 32'd0);
    check("rst_state", dbg_state, 2'd0);
    check("const_ahb", {bus.hsize, bus.hburst, bus.hprot, bus.hmastlock, bus.hexcl},
          {3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
    check("const_apb", {bus.pready, bus.pslverr}, 2'b10);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- register vectors, including bad-length STARTs
    vec[0]  = '{1'b1, R_RAM,    32'hFFFF_FFFF, R_RAM,    32'hFFFF_FFFC, 1'b0};
    vec[1]  = '{1'b1, R_LEN,    32'h0000_01FF, R_LEN,    32'h0000_00FF, 1'b0};
    vec[2]  = '{1'b1, R_CTRL,   32'h0000_0006, R_CTRL,   32'h0000_0006, 1'b0};
    vec[3]  = '{1'b0, R_CTRL,   32'h0,         R_STATUS, 32'h0000_0000, 1'b0};
    vec[4]  = '{1'b1, R_CTRL,   32'h0000_0007, R_STATUS, 32'h0000_0004, 1'b1};
    vec[5]  = '{1'b1, R_STATUS, 32'h0000_0004, R_STATUS, 32'h0000_0000, 1'b0};
    vec[6]  = '{1'b1, R_LEN,    32'h0000_0080, R_LEN,    32'h0000_0080, 1'b0};
    vec[7]  = '{1'b1, R_LEN,    32'h0000_0081, R_LEN,    32'h0000_0081, 1'b0};
    vec[8]  = '{1'b1, R_CTRL,   32'h0000_0005, R_STATUS, 32'h0000_0004, 1'b1};
    vec[9]  = '{1'b1, R_STATUS, 32'h0000_0002, R_STATUS, 32'h0000_0004, 1'b1};
    vec[10] = '{1'b1, R_STATUS, 32'h0000_0004, R_STATUS, 32'h0000_0000, 1'b0};
    vec[11] = '{1'b1, R_LEN,    32'h0000_0000, R_LEN,    32'h0000_0000, 1'b0};
    vec[12] = '{1'b1, R_CTRL,   32'h0000_0001, R_STATUS, 32'h0000_0004, 1'b0};
    vec[13] = '{1'b1, R_STATUS, 32'h0000_0007, R_STATUS, 32'h0000_0000, 1'b0};
    vec[14] = '{1'b0, R_CTRL,   32'h0,         R_CTRL,   32'h0000_0000, 1'b0};
    nb = nonseq_cnt;
    for (int i = 0; i < NV; i++) begin
      if (vec[i].we) apb_write(vec[i].wreg, vec[i].wdata);
      apb_read(vec[i].rreg, rd);
      check($sformatf("regvec%0d_rd", i), rd, vec[i].exp_rd);
      check($sformatf("regvec%0d_irq", i), irq, vec[i].exp_irq);
    end
    check("badlen_no_nonseq", nonseq_cnt - nb, 0);
    check("badlen_htrans", bus.htrans, 2'b00);

    // ---- buffer -> RAM, 4 words, zero wait
    preload_buf(32'hA0);
    ws = 0;
    nb = nonseq_cnt; wb = wr_addr_q.size();
    apb_write(R_RAM, 32'h2000);
    apb_write(R_LEN, 32'd4);
    apb_write(R_CTRL, 32'h1);
    wait_status("t1", 32'h2, 100, cyc);
    check("t1_cycles", cyc, 8);
    check("t1_status", bus.prdata, 32'h2);
    for (int i = 0; i < 4; i++) exp_q.push_back({32'h2000 + 32'(4 * i), 32'hA0 + 32'(i)});
    check_writes("t1", wb);
    check("t1_nonseq", nonseq_cnt - nb, 4);

    // ---- RAM -> buffer, 3 words, irq and W1C
    ram[32'h3000] = 32'h11; ram[32'h3004] = 32'h22; ram[32'h3008] = 32'h33;
    bb = bw_idx_q.size();
    apb_write(R_RAM, 32'h3000);
    apb_write(R_LEN, 32'd3);
    apb_write(R_CTRL, 32'h7);
    wait_status("t2", 32'h2, 100, cyc);
    check("t2_cycles", cyc, 6);
    check("t2_last_we_with_done", bus.buf_we, 1'b1);
    check("t2_irq", irq, 1'b1);
    @(negedge clk);
    exp_q.push_back({32'd0, 32'h11});
    exp_q.push_back({32'd1, 32'h22});
    exp_q.push_back({32'd2, 32'h33});
    check_bufwrites("t2", bb);
    apb_write(R_STATUS, 32'h2);
    check("t2_irq_clr", irq, 1'b0);
    apb_read(R_STATUS, rd);
    check("t2_status_clr", rd, 32'h0);

    // ---- DONE set on the same edge as a DONE W1C: set wins
    apb_write(R_CTRL, 32'h0);
    apb_write(R_RAM, 32'hA000);
    apb_write(R_LEN, 32'd1);
    apb_write(R_CTRL, 32'h1);
    apb_write(R_STATUS, 32'h2);
    apb_read(R_STATUS, rd);
    check("setwins_status", rd, 32'h2);
    apb_write(R_STATUS, 32'h2);

    // ---- START / RAM_ADDR / LEN / DIR writes while busy are ignored
    preload_buf(32'hC0);
    nb = nonseq_cnt; wb = wr_addr_q.size();
    apb_write(R_RAM, 32'h5000);
    apb_write(R_LEN, 32'd6);
    apb_write(R_CTRL, 32'h1);
    apb_write(R_RAM, 32'h9000);
    apb_write(R_CTRL, 32'h3);
    apb_write(R_LEN, 32'd1);
    wait_status("t5", 32'h2, 100, cyc);
    for (int i = 0; i < 6; i++) exp_q.push_back({32'h5000 + 32'(4 * i), 32'hC0 + 32'(i)});
    check_writes("t5", wb);
    check("t5_nonseq", nonseq_cnt - nb, 6);
    apb_read(R_RAM, rd);
    check("t5_ram_addr", rd, 32'h5000);
    apb_read(R_LEN, rd);
    check("t5_len", rd, 32'd6);
    apb_read(R_CTRL, rd);
    check("t5_ctrl", rd, 32'h0);
    apb_write(R_STATUS, 32'h2);

    // ---- AHB error on word 2 of a 5-word RAM -> buffer transfer
    for (int i = 0; i < 5; i++) ram[32'h6000 + 32'(4 * i)] = 32'h6600 + 32'(i);
    nb = nonseq_cnt; bb = bw_idx_q.size();
    err_word = nonseq_cnt + 2;
    apb_write(R_RAM, 32'h6000);
    apb_write(R_LEN, 32'd5);
    apb_write(R_CTRL, 32'h3);
    wait_status("t4", 32'h6, 100, cyc);
    check("t4_status", bus.prdata, 32'h4);
    repeat (4) @(negedge clk);
    #1;
    check("t4_htrans_idle", bus.htrans, 2'b00);
    check("t4_nonseq", nonseq_cnt - nb, 3);
    exp_q.push_back({32'd0, 32'h6600});
    exp_q.push_back({32'd1, 32'h6601});
    check_bufwrites("t4", bb);
    err_word = -1;
    apb_write(R_STATUS, 32'h4);

    // ---- 128 words, buffer -> RAM, two wait states per data phase
    preload_buf(32'hB000_0000);
    ws = 2;
    nb = nonseq_cnt; wb = wr_addr_q.size();
    apb_write(R_CTRL, 32'h0);
    apb_write(R_RAM, 32'h4000);
    apb_write(R_LEN, 32'd128);
    apb_write(R_CTRL, 32'h1);
    wait_status("t3", 32'h2, 2000, cyc);
    check("t3_cycles", cyc, 512);
    check("t3_status", bus.prdata, 32'h2);
    check("t3_nonseq", nonseq_cnt - nb, 128);
    for (int i = 0; i < 128; i++) exp_q.push_back({32'h4000 + 32'(4 * i), 32'hB000_0000 + 32'(i)});
    check_writes("t3", wb);
    ws = 0;

    // ---- reset during word 10 of a 128-word transfer, then a clean restart
    preload_buf(32'hD0);
    apb_write(R_STATUS, 32'h2);
    apb_write(R_RAM, 32'h8000);
    apb_write(R_CTRL, 32'h1);
    nb = nonseq_cnt;
    bus.paddr = {12'd0, R_STATUS, 2'b00};
    n = 0;
    while ((nonseq_cnt - nb < 11) && (n < 500)) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_word10", nonseq_cnt - nb, 11);
    #2 rst_n = 1'b0;
    #1;
    check("t6_htrans", bus.htrans, 2'b00);
    check("t6_haddr", bus.haddr, 32'd0);
    check("t6_buf_we", bus.buf_we, 1'b0);
    check("t6_status", bus.prdata, 32'd0);
    check("t6_irq", irq, 1'b0);
    check("t6_state", dbg_state, 2'd0);
    wb = wr_addr_q.size();
    n = nonseq_cnt;
    repeat (3) @(negedge clk);
    check("t6_no_more_writes", wr_addr_q.size() - wb, 0);
    check("t6_no_more_nonseq", nonseq_cnt - n, 0);
    rst_n = 1'b1;
    @(negedge clk);
    apb_write(R_RAM, 32'h7000);
    apb_write(R_LEN, 32'd2);
    apb_write(R_CTRL, 32'h1);
    wait_status("t6b", 32'h2, 100, cyc);
    check("t6b_cycles", cyc, 4);
    exp_q.push_back({32'h7000, 32'hD0});
    exp_q.push_back({32'h7004, 32'hD1});
    check_writes("t6b", wb);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
